// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } arb_state_t;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_LDR = 1'b1;

   localparam int unsigned ADDR_W_DEF  = 12;
   localparam int unsigned DATA_W_DEF  = 16;
   localparam int unsigned MEM_LAT_DEF = 2;
   localparam int unsigned CNT_W       = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the controller and loader ports sharing one memory,
// sequencing each grant through a fixed-latency read/write and a ready pulse.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = ADDR_W_DEF,
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned MEM_LAT = MEM_LAT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ready,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   output logic              ldr_ready,
   output logic [DATA_W-1:0] ldr_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   // On a tie the requester that did not win last time is picked.
   function automatic logic rr_pick(input logic c_req, input logic l_req, input logic last);
      if (c_req && l_req) return ~last;
      return c_req ? REQ_CPU : REQ_LDR;
   endfunction

   arb_state_t        state_q, state_d;
   logic              last_gnt_q, last_gnt_d;
   logic              gnt_q, gnt_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              cpu_ready_q, cpu_ready_d;
   logic              ldr_ready_q, ldr_ready_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;
   logic              busy_q, busy_d;

   logic              pick_s;
   logic              any_req_s;
   logic              capture_s;

   assign pick_s    = rr_pick(cpu_req, ldr_req, last_gnt_q);
   assign any_req_s = cpu_req | ldr_req;
   assign capture_s = (state_q == WAIT) && (cnt_q == CNT_ONE);

   // State, transaction latch and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         last_gnt_q  <= REQ_LDR;
         gnt_q       <= REQ_CPU;
         we_q        <= 1'b0;
         addr_q      <= {ADDR_W{1'b0}};
         wdata_q     <= {DATA_W{1'b0}};
         cnt_q       <= {CNT_W{1'b0}};
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= {ADDR_W{1'b0}};
         mem_wdata_q <= {DATA_W{1'b0}};
         cpu_ready_q <= 1'b0;
         ldr_ready_q <= 1'b0;
         cpu_rdata_q <= {DATA_W{1'b0}};
         ldr_rdata_q <= {DATA_W{1'b0}};
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_gnt_q  <= last_gnt_d;
         gnt_q       <= gnt_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cnt_q       <= cnt_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_ready_q <= cpu_ready_d;
         ldr_ready_q <= ldr_ready_d;
         cpu_rdata_q <= cpu_rdata_d;
         ldr_rdata_q <= ldr_rdata_d;
         busy_q      <= busy_d;
      end
   end

   // Next-state logic: grant in IDLE, issue, count read latency, complete.
   always_comb begin
      state_d    = state_q;
      last_gnt_d = last_gnt_q;
      gnt_d      = gnt_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      cnt_d      = cnt_q;
      case (state_q)
         IDLE: begin
            if (any_req_s) begin
               gnt_d      = pick_s;
               last_gnt_d = pick_s;
               if (pick_s == REQ_CPU) begin
                  we_d    = cpu_we;
                  addr_d  = cpu_addr;
                  wdata_d = cpu_wdata;
               end else begin
                  we_d    = ldr_we;
                  addr_d  = ldr_addr;
                  wdata_d = ldr_wdata;
               end
               state_d = ISSUE;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            if (we_q) begin
               state_d = DONE;
            end else begin
               cnt_d   = CNT_INIT;
               state_d = WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               state_d = DONE;
            end else begin
               state_d = WAIT;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs are registered, so they are derived from the state being entered.
   always_comb begin
      mem_en_d    = (state_d == ISSUE);
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cpu_ready_d = (state_d == DONE) && (gnt_q == REQ_CPU);
      ldr_ready_d = (state_d == DONE) && (gnt_q == REQ_LDR);
      cpu_rdata_d = cpu_rdata_q;
      ldr_rdata_d = ldr_rdata_q;
      busy_d      = (state_d != IDLE);
      if (state_d == ISSUE) begin
         mem_we_d    = we_d;
         mem_addr_d  = addr_d;
         mem_wdata_d = wdata_d;
      end else begin
         mem_we_d    = mem_we_q;
         mem_addr_d  = mem_addr_q;
         mem_wdata_d = mem_wdata_q;
      end
      if (capture_s && (gnt_q == REQ_CPU)) begin
         cpu_rdata_d = mem_rdata;
      end else if (capture_s && (gnt_q == REQ_LDR)) begin
         ldr_rdata_d = mem_rdata;
      end else begin
         cpu_rdata_d = cpu_rdata_q;
         ldr_rdata_d = ldr_rdata_q;
      end
   end

   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cpu_ready = cpu_ready_q;
   assign ldr_ready = ldr_ready_q;
   assign cpu_rdata = cpu_rdata_q;
   assign ldr_rdata = ldr_rdata_q;
   assign busy      = busy_q;

endmodule
